// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Run controller for the SRAM-fed compute engine. A rising edge on dut_run
//   (seen in idle) starts a run. The run reads a two-word header {L, V} from
//   input SRAM. It then streams V input vectors of length L against one weight
//   vector and accumulates signed products. One saturated result per vector
//   is written to output SRAM.
//
// Ports
//   clk, reset_b                 clock (rising edge), async active-low reset
//   dut_run / dut_busy           start request / run-in-progress flag
//   dut_sram_read_address        input SRAM address (data returns next cycle)
//   sram_dut_read_data           input SRAM read data
//   dut_wmem_read_address        weight SRAM address (data returns next cycle)
//   wmem_dut_read_data           weight SRAM read data
//   dut_sram_write_enable        output SRAM write strobe (one cycle per result)
//   dut_sram_write_address/data  output SRAM write address / saturated result
module dot_product_sequencer #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned IN_BASE  = 2,
  parameter int unsigned OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SatMax =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StHdr2, StStream, StDrain, StWrite, StFin
  } state_e;

  state_e                    state_q, state_d;
  logic                      run_prev_q;
  logic                      busy_q, busy_d;
  logic [DATA_W-1:0]         len_q, len_d;
  logic [DATA_W-1:0]         num_q, num_d;
  logic [DATA_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]         vec_q, vec_d;
  logic [ADDR_W-1:0]         ptr_q, ptr_d;
  logic                      mac_vld_q, mac_vld_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      we_q, we_d;
  logic [ADDR_W-1:0]         waddr_q, waddr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;

  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > SatMax)      return SatMax[DATA_W-1:0];
    else if (a < SatMin) return SatMin[DATA_W-1:0];
    else                 return a[DATA_W-1:0];
  endfunction

  // Operands arrive one cycle after their addresses; mac_vld_q marks them.
  assign prod     = $signed(sram_dut_read_data) * $signed(wmem_dut_read_data);
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    num_d     = num_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    ptr_d     = ptr_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    mac_vld_d = (state_q == StStream);
    acc_d     = mac_vld_q ? (acc_q + prod_ext) : acc_q;

    unique case (state_q)
      StIdle: begin
        if (dut_run && !run_prev_q) state_d = StHdr0;
      end
      StHdr0: state_d = StHdr1;
      StHdr1: begin
        len_d   = sram_dut_read_data;
        state_d = StHdr2;
      end
      StHdr2: begin
        num_d = sram_dut_read_data;
        idx_d = '0;
        vec_d = '0;
        ptr_d = ADDR_W'(IN_BASE);
        acc_d = '0;
        if (len_q == '0 || sram_dut_read_data == '0) state_d = StFin;
        else                                          state_d = StStream;
      end
      StStream: begin
        // ptr_q tracks IN_BASE + v*L + i without a multiplier.
        idx_d = idx_q + DATA_W'(1);
        ptr_d = ptr_q + ADDR_W'(1);
        if (idx_q == len_q - DATA_W'(1)) state_d = StDrain;
      end
      StDrain: begin
        // acc_d already includes the final product.
        we_d    = 1'b1;
        waddr_d = ADDR_W'(OUT_BASE) + vec_q[ADDR_W-1:0];
        wdata_d = sat(acc_d);
        state_d = StWrite;
      end
      StWrite: begin
        acc_d = '0;
        idx_d = '0;
        vec_d = vec_q + DATA_W'(1);
        if (vec_q + DATA_W'(1) == num_q) state_d = StFin;
        else                              state_d = StStream;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      run_prev_q <= 1'b0;
      busy_q     <= 1'b0;
      len_q      <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      vec_q      <= '0;
      ptr_q      <= '0;
      mac_vld_q  <= 1'b0;
      acc_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_prev_q <= dut_run;
      busy_q     <= busy_d;
      len_q      <= len_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      vec_q      <= vec_d;
      ptr_q      <= ptr_d;
      mac_vld_q  <= mac_vld_d;
      acc_q      <= acc_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Read addresses decode from registered state only.
  always_comb begin
    dut_sram_read_address = '0;
    dut_wmem_read_address = '0;
    case (state_q)
      StHdr1:   dut_sram_read_address = ADDR_W'(1);
      StStream: begin
        dut_sram_read_address = ptr_q;
        dut_wmem_read_address = idx_q[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  assign dut_busy               = busy_q;
  assign dut_sram_write_enable  = we_q;
  assign dut_sram_write_address = waddr_q;
  assign dut_sram_write_data    = wdata_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
module tb_dot_product_sequencer;

  logic        clk;
  logic        reset_b;
  logic        dut_run;
  logic        dut_busy;
  logic [11:0] dut_sram_read_address;
  logic [15:0] sram_dut_read_data;
  logic [11:0] dut_wmem_read_address;
  logic [15:0] wmem_dut_read_data;
  logic        dut_sram_write_enable;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;

  logic [15:0] in_mem [4096];
  logic [15:0] w_mem  [4096];

  int          n_vec = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic [11:0] wa_q [$];
  logic [15:0] wd_q [$];

  dot_product_sequencer dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM models.
  always @(posedge clk) begin
    sram_dut_read_data <= in_mem[dut_sram_read_address];
    wmem_dut_read_data <= w_mem[dut_wmem_read_address];
  end

  always @(negedge clk) begin
    if (dut_busy) busy_cnt++;
    if (dut_sram_write_enable) begin
      wa_q.push_back(dut_sram_write_address);
      wd_q.push_back(dut_sram_write_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed dot product, then clamp to 16 bits.
  function automatic logic [15:0] ref_dot(input int l, input int k);
    longint s = 0;
    for (int i = 0; i < l; i++) begin
      s += longint'($signed(in_mem[(2 + k * l + i) % 4096])) *
           longint'($signed(w_mem[i % 4096]));
    end
    if (s > 32767)       return 16'h7FFF;
    else if (s < -32768) return 16'h8000;
    else                 return 16'(s);
  endfunction

  task automatic set_hdr(input int l, input int v);
    in_mem[0] = 16'(l);
    in_mem[1] = 16'(v);
  endtask

  // mode 0: one-cycle pulse, 1: held high through and after run, 2: toggled mid-run
  task automatic do_run(input string tag, input int l, input int v, input int mode);
    logic [15:0] exp_d [$];
    int          exp_busy;
    int          c;
    bit          seen;
    exp_busy = (l == 0 || v == 0) ? 4 : 4 + v * (l + 2);
    if (l != 0)
      for (int k = 0; k < v; k++) exp_d.push_back(ref_dot(l, k));
    wa_q.delete();
    wd_q.delete();
    busy_cnt = 0;
    @(negedge clk);
    dut_run = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!dut_busy && c < 20);
    if (!dut_busy) begin
      check({tag, "_busy_rise"}, 64'(dut_busy), 64'(1));
      dut_run = 1'b0;
      return;
    end
    if (mode == 0) dut_run = 1'b0;
    c = 0;
    while (dut_busy && c < exp_busy + 20) begin
      if (mode == 2) dut_run = (c < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      c++;
    end
    check({tag, "_busy_fall"}, 64'(dut_busy), 64'(0));
    if (mode == 1) begin
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (dut_busy) seen = 1'b1;
      end
      check({tag, "_no_restart"}, 64'(seen), 64'(0));
      dut_run = 1'b0;
    end
    repeat (2) @(negedge clk);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({tag, "_n_writes"}, 64'(wa_q.size()), 64'(exp_d.size()));
    for (int k = 0; k < exp_d.size() && k < wa_q.size(); k++) begin
      check($sformatf("%s_waddr%0d", tag, k), 64'(wa_q[k]), 64'(k % 4096));
      check($sformatf("%s_wdata%0d", tag, k), 64'(wd_q[k]), 64'(exp_d[k]));
    end
  endtask

  initial begin
    int l;
    int v;
    int c;
    for (int a = 0; a < 4096; a++) begin
      in_mem[a] = '0;
      w_mem[a]  = '0;
    end
    reset_b = 1'b0;
    dut_run = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(dut_busy), 64'(0));
    check("rst_we", 64'(dut_sram_write_enable), 64'(0));
    check("rst_raddr", 64'(dut_sram_read_address), 64'(0));
    check("rst_waddr_w", 64'(dut_wmem_read_address), 64'(0));
    check("rst_waddr", 64'(dut_sram_write_address), 64'(0));
    check("rst_wdata", 64'(dut_sram_write_data), 64'(0));
    reset_b = 1'b1;
    @(negedge clk);

    // Basic two-vector run.
    set_hdr(3, 2);
    in_mem[2] = 16'd1; in_mem[3] = 16'd2; in_mem[4] = 16'd3;
    in_mem[5] = 16'hFFFF; in_mem[6] = 16'd0; in_mem[7] = 16'd4;
    w_mem[0] = 16'd2; w_mem[1] = 16'd3; w_mem[2] = 16'd4;
    do_run("t1", 3, 2, 0);
    check("t1_out0", 64'(wd_q.size() > 0 ? wd_q[0] : 16'hDEAD), 64'(20));
    check("t1_out1", 64'(wd_q.size() > 1 ? wd_q[1] : 16'hDEAD), 64'(14));

    // Positive saturation.
    set_hdr(2, 1);
    in_mem[2] = 16'h7FFF; in_mem[3] = 16'h7FFF;
    w_mem[0] = 16'h7FFF; w_mem[1] = 16'h7FFF;
    do_run("t2", 2, 1, 0);

    // Negative saturation and its mirror.
    set_hdr(1, 1);
    in_mem[2] = 16'h8000;
    w_mem[0] = 16'd2;
    do_run("t3a", 1, 1, 0);
    w_mem[0] = 16'hFFFF;
    do_run("t3b", 1, 1, 0);

    // Empty runs.
    set_hdr(5, 0);
    do_run("t4", 5, 0, 0);
    set_hdr(0, 3);
    do_run("t4b", 0, 3, 0);

    // Held and toggled dut_run.
    set_hdr(4, 3);
    for (int a = 2; a < 14; a++) in_mem[a] = 16'($urandom_range(0, 400)) - 16'd200;
    for (int a = 0; a < 4; a++) w_mem[a] = 16'($urandom_range(0, 400)) - 16'd200;
    do_run("t5h", 4, 3, 1);
    do_run("t5t", 4, 3, 2);

    // Abort during vector 1, then a clean rerun.
    wa_q.delete();
    wd_q.delete();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    c = 0;
    while (wa_q.size() == 0 && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("t6_first_write", 64'(wa_q.size()), 64'(1));
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check("t6_abort_busy", 64'(dut_busy), 64'(0));
    check("t6_abort_we", 64'(dut_sram_write_enable), 64'(0));
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_abort_writes", 64'(wa_q.size()), 64'(1));
    do_run("t6r", 4, 3, 0);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      v = $urandom_range(0, 4);
      set_hdr(l, v);
      for (int a = 2; a < 2 + l * v; a++)
        in_mem[a] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF)
                                                : 16'($urandom);
      for (int a = 0; a < l; a++) w_mem[a] = 16'($urandom);
      do_run($sformatf("rnd%0d", r), l, v, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
